sram_mem_ctrl: RTL and testbench
================================

Name: sram_mem_ctrl

Overview:
- Memory controller between the ibex core's instruction/data ports and a set of sky130 1rw1r 32x256 SRAM banks, plus a host loader port (testbench/debug preload).
- Implements the core's req/gnt/rvalid protocol and decodes addresses to bank and word.
- Arbitrates each bank's rw port between core-data and host requesters; drives each bank's read-only port from the instruction fetch.
- Addresses beyond SRAM are answered with an error response; no bank is accessed.

Parameters:
- NUM_BANKS, 2, number of SRAM macros (power of two).
- BANK_WORDS, 256, 32-bit words per macro.
- WORD_AW, 8, log2(BANK_WORDS).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- data_req_i  in  1  core data request
- data_gnt_o  out  1  data grant
- data_rvalid_o  out  1  data response valid
- data_we_i  in  1  data write enable
- data_be_i  in  4  byte enables
- data_addr_i  in  32  byte address
- data_wdata_i  in  32  write data
- data_rdata_o  out  32  read data
- data_err_o  out  1  data error, valid with rvalid
- instr_req_i  in  1  fetch request
- instr_gnt_o  out  1  fetch grant
- instr_rvalid_o  out  1  fetch response valid
- instr_addr_i  in  32  fetch byte address
- instr_rdata_o  out  32  fetched word
- instr_err_o  out  1  fetch error
- host_req_i  in  1  host request
- host_we_i  in  1  host write
- host_addr_i  in  32  host byte address
- host_wdata_i  in  32  host write data (full word)
- host_gnt_o  out  1  host grant
- host_rvalid_o  out  1  host response valid
- host_rdata_o  out  32  host read data
- host_err_o  out  1  host error
- sram_csb0_o  out  NUM_BANKS  per-bank port-0 chip select (active low)
- sram_web0_o  out  NUM_BANKS  per-bank write enable (active low)
- sram_wmask0_o  out  4*NUM_BANKS  per-bank byte mask
- sram_addr0_o  out  WORD_AW*NUM_BANKS  per-bank port-0 word address
- sram_din0_o  out  32*NUM_BANKS  per-bank write data
- sram_dout0_i  in  32*NUM_BANKS  per-bank port-0 read data
- sram_csb1_o  out  NUM_BANKS  per-bank port-1 chip select
- sram_addr1_o  out  WORD_AW*NUM_BANKS  per-bank port-1 word address
- sram_dout1_i  in  32*NUM_BANKS  per-bank port-1 read data

Behaviour:
- Decode: word = addr[WORD_AW+1:2]; bank = addr[WORD_AW+1+log2(NUM_BANKS):WORD_AW+2]. In range iff addr < NUM_BANKS*BANK_WORDS*4 (default 0x800). addr[1:0] ignored.
- Grants are combinational in cycle T. The response is registered: rvalid is asserted in T+1 for reads and writes, lasts 1 cycle, with a registered bank select used to mux dout. One outstanding request per requester; a requester may issue a new request in T+1.
- Instr: always granted when req=1; it never conflicts because port 1 is dedicated. In range: csb1[bank]=0, addr1[bank]=word.
- Port 0 arbitration, per bank:
  - If data and host target different banks, both are granted in the same cycle.
  - If they target the same bank, a per-bank round-robin bit decides; the loser sees gnt=0 and holds its request.
  - The RR bit flips only on a contested grant. Reset value favours data.
- Writes:
  - Data: web0=0, wmask0=data_be_i.
  - Host: wmask0=4'b1111.
  - rdata on a write response is don't-care; the bench checks 0.
- Out-of-range request: granted immediately, with no csb asserted. Next cycle: rvalid=1, err=1, rdata=0.
- Idle: csb0/csb1 = all 1, web0 = all 1, wmask0=0, addresses 0.
- Reset (async, any time): rvalid_q/err_q for all requesters=0, RR bits=data-favoured, registered bank selects=0. A response pending at reset is dropped.
- rdata outputs are 0 whenever rvalid=0.

Decomposition:
- Package sram_ctrl_pkg: bank/word decode function, SRAM_BYTES constant, requester enum {REQ_DATA, REQ_HOST}.
- Sub-module sram_bank_arb: one instance per bank; 2-way round-robin for port 0 plus mux of addr/din/wmask/web.
- Top-level holds decode, response registers and rdata muxes.

Test Plan:
- Data write 0xDEADBEEF to 0x104 with be=4'b1111, then read 0x104 → gnt same cycle; rvalid next cycle; rdata=0xDEADBEEF; bank0 word 0x41 accessed.
- Host writes 0x12345678 to 0x400; instr fetch from 0x400 → instr_rdata=0x12345678 at T+1, err=0, csb1[1]=0.
- Data and host both read bank0 in the same cycle → data granted first (reset RR), host granted next cycle. Repeat contention → host granted first.
- Data reads 0x000 and host reads 0x404 in the same cycle → both granted, both rvalid at T+1 with correct words.
- Data read 0x800 → gnt=1, all csb high, rvalid at T+1 with err=1, rdata=0.
- Byte write be=4'b0010 of 0xAABBCCDD to a word holding 0 → readback 0x0000CC00. rst_ni pulsed while a read is pending → rvalid stays 0.

Source files
------------

// File: rtl/sram_ctrl_pkg.sv
// Shared types and address-decode helpers for the SRAM memory controller.
// Decode helpers take the geometry as arguments so parameter overrides stay consistent.
package sram_ctrl_pkg;

    localparam int unsigned DEF_NUM_BANKS  = 2;
    localparam int unsigned DEF_BANK_WORDS = 256;
    localparam int unsigned DEF_WORD_AW    = 8;
    localparam logic [31:0] SRAM_BYTES     = 32'(DEF_NUM_BANKS * DEF_BANK_WORDS * 4);

    typedef enum logic {
        REQ_DATA = 1'b0,
        REQ_HOST = 1'b1
    } req_e;

    function automatic logic addr_in_range(input logic [31:0] addr, input logic [31:0] mem_bytes);
        return addr < mem_bytes;
    endfunction

    // Callers truncate the results to the bank / word address width.
    function automatic logic [31:0] addr_bank(input logic [31:0] addr, input int unsigned word_aw);
        return addr >> (word_aw + 2);
    endfunction

    function automatic logic [31:0] addr_word(input logic [31:0] addr);
        return addr >> 2;
    endfunction

endpackage

// File: rtl/sram_bank_arb.sv
// Per-bank port-0 arbiter: 2-way round-robin between core data and host,
// and the mux of address / write data / mask / write enable onto the macro.
module sram_bank_arb
    import sram_ctrl_pkg::*;
#(
    parameter int unsigned WORD_AW = 8
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               data_sel,
    input  logic               data_we,
    input  logic [3:0]         data_be,
    input  logic [WORD_AW-1:0] data_word,
    input  logic [31:0]        data_wdata,
    input  logic               host_sel,
    input  logic               host_we,
    input  logic [WORD_AW-1:0] host_word,
    input  logic [31:0]        host_wdata,
    output logic               data_gnt,
    output logic               host_gnt,
    output logic               csb0,
    output logic               web0,
    output logic [3:0]         wmask0,
    output logic [WORD_AW-1:0] addr0,
    output logic [31:0]        din0
);

    req_e rr_q;
    logic contested;

    assign contested = data_sel && host_sel;

    always_comb begin
        // NOTE: every output gets a default first so no path through the block infers a latch.
        data_gnt = data_sel && (!contested || rr_q == REQ_DATA);
        host_gnt = host_sel && (!contested || rr_q == REQ_HOST);
        csb0     = 1'b1;
        web0     = 1'b1;
        wmask0   = 4'b0000;
        addr0    = '0;
        din0     = '0;
        if (data_gnt) begin
            csb0  = 1'b0;
            web0  = !data_we;
            addr0 = data_word;
            if (data_we) begin
                wmask0 = data_be;
                din0   = data_wdata;
            end
        end else if (host_gnt) begin
            csb0  = 1'b0;
            web0  = !host_we;
            addr0 = host_word;
            if (host_we) begin
                wmask0 = 4'b1111;
                din0   = host_wdata;
            end
        end
    end

    // Priority only moves when both requesters actually collided on this bank.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_q <= REQ_DATA;
        end else if (contested) begin
            // NOTE: sequential state uses non-blocking assignments so all flops update together.
            rr_q <= (rr_q == REQ_DATA) ? REQ_HOST : REQ_DATA;
        end
    end

endmodule

// File: rtl/sram_mem_ctrl.sv
// Memory controller between the core's instr/data ports, a host loader port and
// a set of 1rw1r SRAM banks; decode, per-bank arbitration and registered responses.
module sram_mem_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int unsigned NUM_BANKS  = 2,
    parameter int unsigned BANK_WORDS = 256,
    parameter int unsigned WORD_AW    = 8
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          data_req_i,
    output logic                          data_gnt_o,
    output logic                          data_rvalid_o,
    input  logic                          data_we_i,
    input  logic [3:0]                    data_be_i,
    input  logic [31:0]                   data_addr_i,
    input  logic [31:0]                   data_wdata_i,
    output logic [31:0]                   data_rdata_o,
    output logic                          data_err_o,
    input  logic                          instr_req_i,
    output logic                          instr_gnt_o,
    output logic                          instr_rvalid_o,
    input  logic [31:0]                   instr_addr_i,
    output logic [31:0]                   instr_rdata_o,
    output logic                          instr_err_o,
    input  logic                          host_req_i,
    input  logic                          host_we_i,
    input  logic [31:0]                   host_addr_i,
    input  logic [31:0]                   host_wdata_i,
    output logic                          host_gnt_o,
    output logic                          host_rvalid_o,
    output logic [31:0]                   host_rdata_o,
    output logic                          host_err_o,
    output logic [NUM_BANKS-1:0]          sram_csb0_o,
    output logic [NUM_BANKS-1:0]          sram_web0_o,
    output logic [4*NUM_BANKS-1:0]        sram_wmask0_o,
    output logic [WORD_AW*NUM_BANKS-1:0]  sram_addr0_o,
    output logic [32*NUM_BANKS-1:0]       sram_din0_o,
    input  logic [32*NUM_BANKS-1:0]       sram_dout0_i,
    output logic [NUM_BANKS-1:0]          sram_csb1_o,
    output logic [WORD_AW*NUM_BANKS-1:0]  sram_addr1_o,
    input  logic [32*NUM_BANKS-1:0]       sram_dout1_i
);

    localparam int unsigned BANK_AW   = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
    localparam logic [31:0] MEM_BYTES = 32'(NUM_BANKS * BANK_WORDS * 4);

    // rd marks a response that returns macro data; writes and errors return zero.
    typedef struct packed {
        logic               valid;
        logic               err;
        logic               rd;
        logic [BANK_AW-1:0] bank;
    } rsp_t;

    logic               data_hit, host_hit, instr_hit;
    logic [BANK_AW-1:0] data_bank, host_bank, instr_bank;
    logic [WORD_AW-1:0] data_word, host_word, instr_word;
    logic [NUM_BANKS-1:0] data_sel, host_sel, data_gnt_b, host_gnt_b;
    rsp_t data_q, host_q, instr_q;

    assign data_hit   = addr_in_range(data_addr_i, MEM_BYTES);
    assign host_hit   = addr_in_range(host_addr_i, MEM_BYTES);
    assign instr_hit  = addr_in_range(instr_addr_i, MEM_BYTES);
    assign data_bank  = BANK_AW'(addr_bank(data_addr_i, WORD_AW));
    assign host_bank  = BANK_AW'(addr_bank(host_addr_i, WORD_AW));
    assign instr_bank = BANK_AW'(addr_bank(instr_addr_i, WORD_AW));
    assign data_word  = WORD_AW'(addr_word(data_addr_i));
    assign host_word  = WORD_AW'(addr_word(host_addr_i));
    assign instr_word = WORD_AW'(addr_word(instr_addr_i));

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        assign data_sel[b] = data_req_i && data_hit && (data_bank == BANK_AW'(b));
        assign host_sel[b] = host_req_i && host_hit && (host_bank == BANK_AW'(b));

        sram_bank_arb #(.WORD_AW(WORD_AW)) u_arb (
            .clk_i      (clk_i),
            .rst_ni     (rst_ni),
            .data_sel   (data_sel[b]),
            .data_we    (data_we_i),
            .data_be    (data_be_i),
            .data_word  (data_word),
            .data_wdata (data_wdata_i),
            .host_sel   (host_sel[b]),
            .host_we    (host_we_i),
            .host_word  (host_word),
            .host_wdata (host_wdata_i),
            .data_gnt   (data_gnt_b[b]),
            .host_gnt   (host_gnt_b[b]),
            .csb0       (sram_csb0_o[b]),
            .web0       (sram_web0_o[b]),
            .wmask0     (sram_wmask0_o[4*b +: 4]),
            .addr0      (sram_addr0_o[WORD_AW*b +: WORD_AW]),
            .din0       (sram_din0_o[32*b +: 32])
        );

        // Port 1 is fetch-only, so it never needs arbitration.
        assign sram_csb1_o[b] = !(instr_req_i && instr_hit && (instr_bank == BANK_AW'(b)));
        assign sram_addr1_o[WORD_AW*b +: WORD_AW] = sram_csb1_o[b] ? '0 : instr_word;
    end

    // Out-of-range requests are granted at once and answered with an error.
    assign data_gnt_o  = data_req_i && (!data_hit || (|data_gnt_b));
    assign host_gnt_o  = host_req_i && (!host_hit || (|host_gnt_b));
    assign instr_gnt_o = instr_req_i;

    // NOTE: only the small response state is reset; the SRAM contents themselves are never cleared.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            data_q  <= '0;
            host_q  <= '0;
            instr_q <= '0;
        end else begin
            data_q.valid  <= data_gnt_o;
            data_q.err    <= data_gnt_o && !data_hit;
            data_q.rd     <= data_gnt_o && data_hit && !data_we_i;
            host_q.valid  <= host_gnt_o;
            host_q.err    <= host_gnt_o && !host_hit;
            host_q.rd     <= host_gnt_o && host_hit && !host_we_i;
            instr_q.valid <= instr_gnt_o;
            instr_q.err   <= instr_gnt_o && !instr_hit;
            instr_q.rd    <= instr_gnt_o && instr_hit;
            if (data_gnt_o)  data_q.bank  <= data_bank;
            if (host_gnt_o)  host_q.bank  <= host_bank;
            if (instr_gnt_o) instr_q.bank <= instr_bank;
        end
    end

    assign data_rvalid_o  = data_q.valid;
    assign data_err_o     = data_q.err;
    assign data_rdata_o   = data_q.rd ? sram_dout0_i[{data_q.bank, 5'd0} +: 32] : 32'h0;
    assign host_rvalid_o  = host_q.valid;
    assign host_err_o     = host_q.err;
    assign host_rdata_o   = host_q.rd ? sram_dout0_i[{host_q.bank, 5'd0} +: 32] : 32'h0;
    assign instr_rvalid_o = instr_q.valid;
    assign instr_err_o    = instr_q.err;
    assign instr_rdata_o  = instr_q.rd ? sram_dout1_i[{instr_q.bank, 5'd0} +: 32] : 32'h0;

endmodule

// File: tb/tb_sram_mem_ctrl.sv
// Directed bench for sram_mem_ctrl with a behavioural two-bank 1rw1r SRAM model.
module tb_sram_mem_ctrl;

    localparam int NB = 2;
    localparam int AW = 8;

    logic clk_i = 1'b0;
    logic rst_ni;
    logic data_req_i, data_gnt_o, data_rvalid_o, data_we_i, data_err_o;
    logic [3:0] data_be_i;
    logic [31:0] data_addr_i, data_wdata_i, data_rdata_o;
    logic instr_req_i, instr_gnt_o, instr_rvalid_o, instr_err_o;
    logic [31:0] instr_addr_i, instr_rdata_o;
    logic host_req_i, host_we_i, host_gnt_o, host_rvalid_o, host_err_o;
    logic [31:0] host_addr_i, host_wdata_i, host_rdata_o;
    logic [NB-1:0] sram_csb0_o, sram_web0_o, sram_csb1_o;
    logic [4*NB-1:0] sram_wmask0_o;
    logic [AW*NB-1:0] sram_addr0_o, sram_addr1_o;
    logic [32*NB-1:0] sram_din0_o, sram_dout0_i, sram_dout1_i;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk_i = ~clk_i;

    sram_mem_ctrl dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .data_req_i(data_req_i), .data_gnt_o(data_gnt_o), .data_rvalid_o(data_rvalid_o),
        .data_we_i(data_we_i), .data_be_i(data_be_i), .data_addr_i(data_addr_i),
        .data_wdata_i(data_wdata_i), .data_rdata_o(data_rdata_o), .data_err_o(data_err_o),
        .instr_req_i(instr_req_i), .instr_gnt_o(instr_gnt_o), .instr_rvalid_o(instr_rvalid_o),
        .instr_addr_i(instr_addr_i), .instr_rdata_o(instr_rdata_o), .instr_err_o(instr_err_o),
        .host_req_i(host_req_i), .host_we_i(host_we_i), .host_addr_i(host_addr_i),
        .host_wdata_i(host_wdata_i), .host_gnt_o(host_gnt_o), .host_rvalid_o(host_rvalid_o),
        .host_rdata_o(host_rdata_o), .host_err_o(host_err_o),
        .sram_csb0_o(sram_csb0_o), .sram_web0_o(sram_web0_o), .sram_wmask0_o(sram_wmask0_o),
        .sram_addr0_o(sram_addr0_o), .sram_din0_o(sram_din0_o), .sram_dout0_i(sram_dout0_i),
        .sram_csb1_o(sram_csb1_o), .sram_addr1_o(sram_addr1_o), .sram_dout1_i(sram_dout1_i)
    );

    // Behavioural SRAM: synchronous read, byte-masked write on port 0, read-only port 1.
    logic [31:0] mem [NB][256] = '{default: '0};
    logic [31:0] dout0_q [NB] = '{default: '0};
    logic [31:0] dout1_q [NB] = '{default: '0};

    always @(posedge clk_i) begin
        for (int b = 0; b < NB; b++) begin
            if (!sram_csb0_o[b]) begin
                if (!sram_web0_o[b]) begin
                    for (int i = 0; i < 4; i++) begin
                        if (sram_wmask0_o[4*b+i])
                            mem[b][sram_addr0_o[AW*b +: AW]][8*i +: 8] <= sram_din0_o[32*b+8*i +: 8];
                    end
                end else begin
                    dout0_q[b] <= mem[b][sram_addr0_o[AW*b +: AW]];
                end
            end
            if (!sram_csb1_o[b])
                dout1_q[b] <= mem[b][sram_addr1_o[AW*b +: AW]];
        end
    end

    for (genvar b = 0; b < NB; b++) begin : g_dout
        assign sram_dout0_i[32*b +: 32] = dout0_q[b];
        assign sram_dout1_i[32*b +: 32] = dout1_q[b];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic idle();
        data_req_i = 0; data_we_i = 0; data_be_i = 4'h0; data_addr_i = 0; data_wdata_i = 0;
        instr_req_i = 0; instr_addr_i = 0;
        host_req_i = 0; host_we_i = 0; host_addr_i = 0; host_wdata_i = 0;
    endtask

    task automatic resp_edge();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        rst_ni = 1'b0;
        idle();
        #3;
        check("rst_data_rvalid", data_rvalid_o, 0);
        check("rst_host_rvalid", host_rvalid_o, 0);
        check("rst_instr_rvalid", instr_rvalid_o, 0);
        check("idle_csb0", sram_csb0_o, 2'b11);
        check("idle_csb1", sram_csb1_o, 2'b11);
        check("idle_web0", sram_web0_o, 2'b11);
        check("idle_wmask0", sram_wmask0_o, 8'h00);
        check("idle_addr0", sram_addr0_o, 16'h0000);

        // data write then read of 0x104 (bank0 word 0x41)
        @(negedge clk_i);
        rst_ni = 1'b1;
        data_req_i = 1; data_we_i = 1; data_be_i = 4'hF; data_addr_i = 32'h104; data_wdata_i = 32'hDEADBEEF;
        #1;
        check("dwr_gnt", data_gnt_o, 1);
        check("dwr_csb0", sram_csb0_o, 2'b10);
        check("dwr_web0", sram_web0_o, 2'b10);
        check("dwr_wmask0", sram_wmask0_o, 8'h0F);
        check("dwr_addr0", sram_addr0_o, 16'h0041);
        resp_edge();
        check("dwr_rvalid", data_rvalid_o, 1);
        check("dwr_rdata", data_rdata_o, 0);
        @(negedge clk_i);
        data_we_i = 0;
        #1;
        check("drd_gnt", data_gnt_o, 1);
        check("drd_web0", sram_web0_o, 2'b11);
        check("drd_wmask0", sram_wmask0_o, 8'h00);
        resp_edge();
        check("drd_rvalid", data_rvalid_o, 1);
        check("drd_rdata", data_rdata_o, 32'hDEADBEEF);
        check("drd_err", data_err_o, 0);

        // host write 0x400 (bank1 word0), then fetch it
        @(negedge clk_i);
        idle();
        host_req_i = 1; host_we_i = 1; host_addr_i = 32'h400; host_wdata_i = 32'h12345678;
        #1;
        check("hwr_gnt", host_gnt_o, 1);
        check("hwr_csb0", sram_csb0_o, 2'b01);
        check("hwr_wmask0", sram_wmask0_o, 8'hF0);
        resp_edge();
        check("hwr_rvalid", host_rvalid_o, 1);
        check("hwr_rdata", host_rdata_o, 0);
        check("hwr_data_rvalid", data_rvalid_o, 0);
        @(negedge clk_i);
        idle();
        instr_req_i = 1; instr_addr_i = 32'h400;
        #1;
        check("if_gnt", instr_gnt_o, 1);
        check("if_csb1", sram_csb1_o, 2'b01);
        check("if_addr1", sram_addr1_o, 16'h0000);
        check("if_csb0", sram_csb0_o, 2'b11);
        resp_edge();
        check("if_rvalid", instr_rvalid_o, 1);
        check("if_rdata", instr_rdata_o, 32'h12345678);
        check("if_err", instr_err_o, 0);

        // contention on bank0: data first after reset, then host
        @(negedge clk_i);
        idle();
        data_req_i = 1; data_addr_i = 32'h104;
        host_req_i = 1; host_addr_i = 32'h104;
        #1;
        check("c1_data_gnt", data_gnt_o, 1);
        check("c1_host_gnt", host_gnt_o, 0);
        check("c1_csb0", sram_csb0_o, 2'b10);
        resp_edge();
        check("c1_data_rdata", data_rdata_o, 32'hDEADBEEF);
        check("c1_host_rvalid", host_rvalid_o, 0);
        @(negedge clk_i);
        data_req_i = 0;
        #1;
        check("c1_host_gnt_late", host_gnt_o, 1);
        resp_edge();
        check("c1_host_rvalid", host_rvalid_o, 1);
        check("c1_host_rdata", host_rdata_o, 32'hDEADBEEF);
        check("c1_data_rvalid", data_rvalid_o, 0);
        @(negedge clk_i);
        data_req_i = 1;
        #1;
        check("c2_host_gnt", host_gnt_o, 1);
        check("c2_data_gnt", data_gnt_o, 0);
        resp_edge();
        check("c2_host_rvalid", host_rvalid_o, 1);
        @(negedge clk_i);
        host_req_i = 0;
        #1;
        check("c2_data_gnt_late", data_gnt_o, 1);
        resp_edge();
        check("c2_data_rdata", data_rdata_o, 32'hDEADBEEF);

        // parallel writes to different banks, then parallel reads
        @(negedge clk_i);
        idle();
        data_req_i = 1; data_we_i = 1; data_be_i = 4'hF; data_addr_i = 32'h000; data_wdata_i = 32'h11223344;
        host_req_i = 1; host_we_i = 1; host_addr_i = 32'h404; host_wdata_i = 32'h0BADF00D;
        #1;
        check("par_wr_data_gnt", data_gnt_o, 1);
        check("par_wr_host_gnt", host_gnt_o, 1);
        check("par_wr_csb0", sram_csb0_o, 2'b00);
        check("par_wr_addr0", sram_addr0_o, 16'h0100);
        resp_edge();
        check("par_wr_data_rvalid", data_rvalid_o, 1);
        check("par_wr_host_rvalid", host_rvalid_o, 1);
        @(negedge clk_i);
        data_we_i = 0; host_we_i = 0;
        #1;
        check("par_rd_both_gnt", {data_gnt_o, host_gnt_o}, 2'b11);
        resp_edge();
        check("par_rd_data_rdata", data_rdata_o, 32'h11223344);
        check("par_rd_host_rdata", host_rdata_o, 32'h0BADF00D);

        // out-of-range data read and fetch
        @(negedge clk_i);
        idle();
        data_req_i = 1; data_addr_i = 32'h800;
        instr_req_i = 1; instr_addr_i = 32'h1000;
        #1;
        check("oor_data_gnt", data_gnt_o, 1);
        check("oor_instr_gnt", instr_gnt_o, 1);
        check("oor_csb0", sram_csb0_o, 2'b11);
        check("oor_csb1", sram_csb1_o, 2'b11);
        resp_edge();
        check("oor_data_rvalid", data_rvalid_o, 1);
        check("oor_data_err", data_err_o, 1);
        check("oor_data_rdata", data_rdata_o, 0);
        check("oor_instr_err", instr_err_o, 1);
        check("oor_instr_rdata", instr_rdata_o, 0);

        // byte write into a zero word (0x0F0 = bank0 word 0x3C)
        @(negedge clk_i);
        idle();
        data_req_i = 1; data_we_i = 1; data_be_i = 4'b0010; data_addr_i = 32'h0F0; data_wdata_i = 32'hAABBCCDD;
        #1;
        check("bw_wmask0", sram_wmask0_o, 8'h02);
        check("bw_addr0", sram_addr0_o, 16'h003C);
        resp_edge();
        check("bw_err", data_err_o, 0);
        @(negedge clk_i);
        data_we_i = 0;
        resp_edge();
        check("bw_rdata", data_rdata_o, 32'h0000CC00);

        // contest flips priority to host, then reset with a host read in flight
        @(negedge clk_i);
        idle();
        data_req_i = 1; data_addr_i = 32'h000;
        host_req_i = 1; host_addr_i = 32'h000;
        #1;
        check("c3_data_gnt", data_gnt_o, 1);
        resp_edge();
        check("c3_data_rdata", data_rdata_o, 32'h11223344);
        @(negedge clk_i);
        data_req_i = 0;
        #1;
        check("rstp_host_gnt", host_gnt_o, 1);
        #1;
        rst_ni = 1'b0;
        host_req_i = 0;
        #1;
        check("rstp_data_rvalid_async", data_rvalid_o, 0);
        check("rstp_data_rdata_async", data_rdata_o, 0);
        #1;
        rst_ni = 1'b1;
        resp_edge();
        check("rstp_host_rvalid", host_rvalid_o, 0);
        check("rstp_host_rdata", host_rdata_o, 0);

        // priority returns to data after reset
        @(negedge clk_i);
        data_req_i = 1; data_addr_i = 32'h000;
        host_req_i = 1; host_addr_i = 32'h000;
        #1;
        check("c4_data_gnt", data_gnt_o, 1);
        check("c4_host_gnt", host_gnt_o, 0);
        resp_edge();
        check("c4_data_rdata", data_rdata_o, 32'h11223344);

        @(negedge clk_i);
        idle();
        repeat (2) @(posedge clk_i);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
